// File: rtl/izh_pkg.sv
// Shared fixed-point types, constants and FSM encoding for the Izhikevich
// neuron front end. Values are signed Q1.16 in 18 bits (1.0 = 18'sh1_0000).
package izh_pkg;

  localparam int FX_W      = 18;
  localparam int FRAC_BITS = 16;

  typedef logic signed [FX_W-1:0] fx_t;

  localparam fx_t FX_ONE = 18'sh1_0000;
  localparam fx_t FX_MAX = 18'sh1_FFFF;
  localparam fx_t FX_MIN = 18'sh2_0000;

  // Narrow an (FX_W+1)-bit sum back to FX_W bits, clamping instead of wrapping.
  function automatic fx_t fx_sat(input logic signed [FX_W:0] v);
    fx_t r;
    if (v[FX_W] != v[FX_W-1]) begin
      r = v[FX_W] ? FX_MIN : FX_MAX;
    end else begin
      r = v[FX_W-1:0];
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_ISSUE
  } state_t;

endpackage

// File: rtl/izh_sat_add.sv
// Combinational signed adder that clamps to the N-bit range instead of wrapping.
module izh_sat_add
  import izh_pkg::*;
#(
  parameter int N = FX_W
) (
  input  logic signed [N-1:0] i_a,
  input  logic signed [N-1:0] i_b,
  output logic signed [N-1:0] o_sum
);

  logic signed [N:0] w_wide;

  // Generic clamp for widths other than the shared fixed-point format.
  function automatic logic signed [N-1:0] sat_n(input logic signed [N:0] v);
    logic signed [N-1:0] r;
    if (v[N] != v[N-1]) begin
      r = v[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      r = v[N-1:0];
    end
    return r;
  endfunction

  // One extra bit of headroom so the true sum is always representable.
  assign w_wide = {i_a[N-1], i_a} + {i_b[N-1], i_b};

  if (N == FX_W) begin : g_fx
    assign o_sum = fx_sat(w_wide);
  end else begin : g_gen
    assign o_sum = sat_n(w_wide);
  end

endmodule

// File: rtl/izh_synaptic_driver.sv
// Synaptic front end of the Izhikevich core: accepts weighted spike events,
// accumulates them into a decaying current, and every STEP_CYCLES clocks
// presents a saturated current with a one-cycle apply strobe.
module izh_synaptic_driver
  import izh_pkg::*;
#(
  parameter int N              = 18,
  parameter int STEP_CYCLES    = 16,
  parameter int DECAY_SHIFT    = 3,
  parameter int CLEAR_ON_SPIKE = 0,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic signed [N-1:0] ev_weight,
  input  logic signed [N-1:0] i_bias,
  input  logic                is_spiking,
  output logic                apply,
  output logic signed [N-1:0] i_out,
  output logic [CNT_W-1:0]    spike_count
);

  // The counter only has to reach STEP_CYCLES-2 before the ISSUE cycle.
  localparam int SC_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES - 1) : 1;
  localparam logic [SC_W-1:0] LAST_CNT = SC_W'(STEP_CYCLES - 2);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SC_W-1:0]       r_cnt;
  logic signed [N-1:0]   r_acc;
  logic signed [N-1:0]   r_i_out;
  logic [CNT_W-1:0]      r_spike_cnt;

  logic                  w_ready;
  logic                  w_apply;
  logic                  w_accept;
  logic                  w_clear;
  logic                  w_to_issue;
  logic signed [N-1:0]   w_acc_base;
  logic signed [N-1:0]   w_ev_add;
  logic signed [N-1:0]   w_acc_next;
  logic signed [N-1:0]   w_issue_sum;

  // State register; reset lands in IDLE immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and Moore outputs: ready only while accumulating, apply only in ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        w_ready = 1'b1;
        if (!enable)               w_state_nxt = ST_IDLE;
        else if (r_cnt == LAST_CNT) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_apply     = 1'b1;
        w_state_nxt = enable ? ST_ACCUM : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Step counter runs only across consecutive ACCUM cycles; any exit restarts the period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_ACCUM && w_state_nxt == ST_ACCUM) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_accept   = ev_valid & w_ready;
  assign w_clear    = (CLEAR_ON_SPIKE != 0) && is_spiking;
  assign w_to_issue = (r_state == ST_ACCUM) && (w_state_nxt == ST_ISSUE);
  assign w_ev_add   = w_accept ? ev_weight : '0;

  // Accumulator base before adding an event: spike clear beats decay, decay only in ISSUE.
  always_comb begin
    w_acc_base = r_acc;
    if (w_clear) begin
      w_acc_base = '0;
    end else if (r_state == ST_ISSUE) begin
      w_acc_base = r_acc - (r_acc >>> DECAY_SHIFT);
    end
  end

  izh_sat_add #(.N(N)) u_acc_add (
    .i_a   (w_acc_base),
    .i_b   (w_ev_add),
    .o_sum (w_acc_next)
  );

  izh_sat_add #(.N(N)) u_bias_add (
    .i_a   (w_acc_next),
    .i_b   (i_bias),
    .o_sum (w_issue_sum)
  );

  // Accumulator update; the decay never overflows, only event adds need clamping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_acc <= '0;
    else        r_acc <= w_acc_next;
  end

  // Output current is captured on entry to ISSUE and held until the next step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_i_out <= '0;
    else if (w_to_issue) r_i_out <= w_issue_sum;
  end

  // Saturating spike counter for monitoring.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_spike_cnt <= '0;
    end else if (is_spiking && (r_spike_cnt != {CNT_W{1'b1}})) begin
      r_spike_cnt <= r_spike_cnt + 1'b1;
    end
  end

  assign ev_ready    = w_ready;
  assign apply       = w_apply;
  assign i_out       = r_i_out;
  assign spike_count = r_spike_cnt;

endmodule

// File: tb/tb_izh_synaptic_driver.sv
// Bench for izh_synaptic_driver: table-driven per-step vectors plus hand
// sequences for timing, decay, boundary events, spike feedback and reset.
module tb_izh_synaptic_driver;

  localparam int N = 18;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         ev_valid = 1'b0;
  logic         is_spiking = 1'b0;
  logic [N-1:0] ev_weight = '0;
  logic [N-1:0] i_bias = '0;
  logic         ev_ready;
  logic         apply;
  logic [N-1:0] i_out;
  logic [15:0]  spike_count;

  logic         c_enable = 1'b0;
  logic         c_valid = 1'b0;
  logic         c_spk = 1'b0;
  logic [N-1:0] c_weight = '0;
  logic         c_ready;
  logic         c_apply;
  logic [N-1:0] c_i_out;
  logic [1:0]   c_spike_count;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] bias;
    logic [N-1:0] w;
    int           n;
    logic [N-1:0] exp;
  } vec_t;
  vec_t vt[7];

  izh_synaptic_driver dut (
    .clk(clk), .reset(reset), .enable(enable), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_weight(ev_weight), .i_bias(i_bias),
    .is_spiking(is_spiking), .apply(apply), .i_out(i_out),
    .spike_count(spike_count)
  );

  izh_synaptic_driver #(.CLEAR_ON_SPIKE(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .enable(c_enable), .ev_valid(c_valid),
    .ev_ready(c_ready), .ev_weight(c_weight), .i_bias(18'h00000),
    .is_spiking(c_spk), .apply(c_apply), .i_out(c_i_out),
    .spike_count(c_spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic sb_check(input string nm);
    logic [N-1:0] e;
    if (exp_q.size() == 0) begin
      fail_now({nm, "_sb_empty"});
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_i_out"}, 32'(i_out), 32'(e));
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; ev_valid = 1'b0; is_spiking = 1'b0;
    c_enable = 1'b0; c_valid = 1'b0; c_spk = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_ev(input logic [N-1:0] w);
    bit done = 1'b0;
    ev_weight = w;
    ev_valid  = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      if (ev_ready) done = 1'b1;
      @(negedge clk);
    end
    ev_valid = 1'b0;
    if (!done) fail_now("ev_accept");
  endtask

  task automatic wait_apply(input string nm, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 64 && !seen; k++) begin
      @(negedge clk);
      if (apply) begin
        seen = 1'b1;
        cyc  = k;
      end
    end
    if (!seen) begin
      fail_now({nm, "_apply"});
    end else begin
      sb_check(nm);
      chk({nm, "_ready_in_issue"}, 32'(ev_ready), 32'd0);
    end
  endtask

  task automatic wait_c_apply(input string nm);
    bit seen = 1'b0;
    for (int k = 1; k <= 64 && !seen; k++) begin
      @(negedge clk);
      if (c_apply) seen = 1'b1;
    end
    if (!seen) fail_now({nm, "_apply"});
  endtask

  task automatic decay_seq(input string nm, input logic [N-1:0] w,
                           input logic [N-1:0] e1, input logic [N-1:0] e2);
    int cyc;
    do_reset();
    i_bias = '0;
    enable = 1'b1;
    exp_q.push_back(e1);
    send_ev(w);
    wait_apply({nm, "_1"}, cyc);
    exp_q.push_back(e2);
    wait_apply({nm, "_2"}, cyc);
    chk({nm, "_2_cycles"}, 32'(cyc), 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vt[0] = '{18'h02666, 18'h00000, 0, 18'h02666};
    vt[1] = '{18'h00000, 18'h02666, 1, 18'h02666};
    vt[2] = '{18'h00000, 18'h0C000, 3, 18'h1FFFF};
    vt[3] = '{18'h00000, 18'h30000, 3, 18'h20000};
    vt[4] = '{18'h1FFFF, 18'h10000, 1, 18'h1FFFF};
    vt[5] = '{18'h20000, 18'h3FFFF, 1, 18'h20000};
    vt[6] = '{18'h01000, 18'h08000, 2, 18'h11000};

    #1;
    chk("rst_apply", 32'(apply), 32'd0);
    chk("rst_i_out", 32'(i_out), 32'd0);
    chk("rst_ready", 32'(ev_ready), 32'd0);
    chk("rst_spike_count", 32'(spike_count), 32'd0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      i_bias = vt[v].bias;
      enable = 1'b1;
      exp_q.push_back(vt[v].exp);
      for (int e = 0; e < vt[v].n; e++) send_ev(vt[v].w);
      wait_apply($sformatf("vec%0d", v), cyc);
    end

    do_reset();
    i_bias = 18'h02666;
    enable = 1'b1;
    exp_q.push_back(18'h02666);
    wait_apply("per1", cyc);
    chk("per1_cycles", 32'(cyc), 32'd16);
    @(negedge clk);
    chk("per1_width", 32'(apply), 32'd0);
    exp_q.push_back(18'h02666);
    wait_apply("per2", cyc);
    chk("per2_cycles", 32'(cyc + 1), 32'd16);
    exp_q.push_back(18'h02666);
    wait_apply("per3", cyc);
    chk("per3_cycles", 32'(cyc), 32'd16);

    decay_seq("decay_pos", 18'h02666, 18'h02666, 18'h0219A);
    decay_seq("decay_neg", 18'h30000, 18'h30000, 18'h32000);

    do_reset();
    i_bias = '0;
    enable = 1'b1;
    repeat (15) @(negedge clk);
    chk("bnd_ready_last", 32'(ev_ready), 32'd1);
    chk("bnd_apply_last", 32'(apply), 32'd0);
    ev_weight = 18'h01000;
    ev_valid  = 1'b1;
    exp_q.push_back(18'h01000);
    @(negedge clk);
    chk("bnd_apply", 32'(apply), 32'd1);
    sb_check("bnd1");
    chk("bnd_ready_issue", 32'(ev_ready), 32'd0);
    ev_weight = 18'h00800;
    @(negedge clk);
    chk("bnd_ready_after", 32'(ev_ready), 32'd1);
    @(negedge clk);
    ev_valid = 1'b0;
    exp_q.push_back(18'h01600);
    wait_apply("bnd2", cyc);

    do_reset();
    repeat (3) begin
      @(negedge clk) is_spiking = 1'b1;
      @(negedge clk) is_spiking = 1'b0;
    end
    chk("spike_count3", 32'(spike_count), 32'd3);

    do_reset();
    c_enable = 1'b1;
    @(negedge clk);
    chk("clr_ready", 32'(c_ready), 32'd1);
    c_weight = 18'h04000;
    c_valid  = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    c_spk   = 1'b1;
    @(negedge clk);
    c_spk = 1'b0;
    wait_c_apply("clr1");
    chk("clr1_i_out", 32'(c_i_out), 32'd0);
    @(negedge clk);
    c_weight = 18'h00800;
    c_valid  = 1'b1;
    c_spk    = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    c_spk   = 1'b0;
    wait_c_apply("clr2");
    chk("clr2_i_out", 32'(c_i_out), 32'h00800);
    chk("cnt2_two", 32'(c_spike_count), 32'd2);
    repeat (3) begin
      @(negedge clk) c_spk = 1'b1;
      @(negedge clk) c_spk = 1'b0;
    end
    chk("cnt2_sat", 32'(c_spike_count), 32'd3);

    do_reset();
    i_bias = 18'h02666;
    enable = 1'b1;
    exp_q.push_back(18'h02666);
    wait_apply("rst_pre", cyc);
    @(negedge clk) is_spiking = 1'b1;
    @(negedge clk) is_spiking = 1'b0;
    @(negedge clk);
    chk("rst_pre_ready", 32'(ev_ready), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_apply", 32'(apply), 32'd0);
    chk("rst_mid_i_out", 32'(i_out), 32'd0);
    chk("rst_mid_ready", 32'(ev_ready), 32'd0);
    chk("rst_mid_spike_count", 32'(spike_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(18'h02666);
    wait_apply("rst_post", cyc);
    chk("rst_post_cycles", 32'(cyc), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/izh_synaptic_driver.md
Name: izh_synaptic_driver

Overview:
- Upstream stage of the Izhikevich neuron core. Accepts weighted synaptic spike events over a valid/ready handshake and accumulates them into a decaying synaptic current.
- Every STEP_CYCLES clocks, issues one integration step to the core: a one-cycle apply strobe plus a stable, saturated input current i_out.
- Counts the core's is_spiking feedback for monitoring. Optionally clears the synaptic current on a spike.

Parameters:
- N, 18, data width; signed fixed point with 16 fractional bits (18'sh1_0000 = 1.0).
- STEP_CYCLES, 16, clocks per neuron update (apply period); minimum 2.
- DECAY_SHIFT, 3, per-step current decay: acc -= acc>>>DECAY_SHIFT.
- CLEAR_ON_SPIKE, 0, when 1, is_spiking clears the accumulator.
- CNT_W, 16, spike counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run/stop for step generation.
- ev_valid  input  1  synaptic event valid.
- ev_ready  output  1  synaptic event ready.
- ev_weight  input  N  signed event weight.
- i_bias  input  N  signed constant bias current, added at issue.
- is_spiking  input  1  spike flag from the neuron core.
- apply  output  1  one-cycle step strobe to the core.
- i_out  output  N  signed current to the core; held between strobes.
- spike_count  output  CNT_W  saturating spike count.

Behaviour:
- reset low (async): state IDLE, acc=0, step counter=0, apply=0, i_out=0, ev_ready=0, spike_count=0. Reset takes effect immediately; on release, the first edge acts from IDLE.
- FSM states: IDLE, ACCUM, ISSUE.
- IDLE:
  - ev_ready=0, apply=0.
  - enable=1 -> ACCUM with counter=0.
- ACCUM:
  - ev_ready=1; the counter increments each cycle.
  - At counter==STEP_CYCLES-2, the next state is ISSUE, so the period is exactly STEP_CYCLES clocks and apply pulses every STEP_CYCLES cycles.
  - enable=0 -> IDLE; counter cleared, acc retained. An event handshaking in that same cycle is still accepted.
- ISSUE:
  - Lasts one cycle; apply=1 (Moore output of ISSUE), ev_ready=0.
  - Exits to ACCUM (counter=0) if enable=1, else to IDLE.
- Event accept: ev_valid & ev_ready at an edge; acc <= sat(acc + ev_weight). Events are never dropped; the producer holds them while ev_ready=0.
- i_out update: on the ACCUM->ISSUE edge, i_out <= sat(acc_next + i_bias). acc_next includes any event accepted on that same edge. i_out is otherwise stable, so the core sees valid i whenever apply=1.
- Decay: in ISSUE, acc <= acc - (acc>>>DECAY_SHIFT), arithmetic shift, truncation toward -inf.
- Arithmetic and saturation:
  - All sums are computed N+1 bits wide, then saturated to [18'sh2_0000 (-2.0), 18'sh1_FFFF (~1.99998)].
  - acc and i_out never wrap.
- Spike feedback: each cycle with is_spiking=1, spike_count++; it saturates at all-ones, with no wrap.
- CLEAR_ON_SPIKE=1 and is_spiking=1: acc <= 0. This has priority over decay. An event accepted in the same cycle still applies: acc <= sat(0 + ev_weight).
- Simultaneous ISSUE decay and spike clear: the clear wins.
- enable toggled mid-period: the period restarts from counter 0 on re-entry; no partial apply is generated.

Decomposition:
- Shared package izh_pkg:
  - fixed-point typedef (signed N-bit), FRAC_BITS=16;
  - constants FX_ONE, FX_MAX, FX_MIN;
  - function fx_sat for narrowing an (N+1)-bit value to N bits;
  - FSM state enum.
- One natural sub-module, izh_sat_add: a combinational signed adder with saturation. It is instantiated twice: once for the accumulator, once for the bias add.
- The counter and FSM stay inline.

Test Plan:
- Period: enable=1 held, no events, i_bias=0x0_2666 -> apply high exactly 1 cycle every 16 cycles; first pulse 16 cycles after enable; i_out=0x0_2666 at every pulse.
- Accumulate and decay: one event with weight 0x0_2666, i_bias=0 -> i_out=0x0_2666 at the first apply; i_out=0x0_219A at the second apply (0x2666-0x04CC); ev_ready=0 during each apply cycle.
- Saturation: three events of 0x0_C000 in one period -> i_out=0x1_FFFF. Three events of 0x3_0000 (-1.0) -> i_out=0x2_0000.
- Boundary event: an event of 0x0_1000 accepted on the last ACCUM cycle -> included in that step's i_out (0x0_1000). A producer holding ev_valid through ISSUE is accepted on the next ACCUM cycle.
- Spike feedback: is_spiking pulsed 3 times -> spike_count=3. With CLEAR_ON_SPIKE=1, acc=0x0_4000 plus a spike, and no events -> next i_out=0. With CNT_W=2 and 5 spikes -> spike_count=3.
- Reset mid-operation: reset asserted low mid-ACCUM, without waiting for a clock edge -> apply, i_out, ev_ready and spike_count are 0 immediately. After release with enable=1 -> first apply 16 cycles later.
